// File: rtl/tinyqv_uart_tx_periph.sv
// UART transmitter peripheral: TX FIFO, programmable bit divisor, empty irq.
// Ports: clk/rst, CPU bus (sel, data_addr, data_write_n, data_read_n,
//   data_in, data_out, data_ready), uart_txd serial out, irq_empty level.
module tinyqv_uart_tx_periph #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  data_addr,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [15:0]   divisor;
  logic [15:0]   cnt, cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          txd_n;
  logic          pop;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_full, fifo_empty;
  logic [7:0]    head;

  logic          wr_req, rd_req;
  logic          a_tx, a_stat, a_div;
  logic          wr_done;
  logic          wr_acc, push;
  logic [31:0]   status;
  logic          unused_ok;

  assign unused_ok = &{1'b0, data_in[31:16]};

  assign wr_req = sel && (data_write_n != 2'b11);
  assign rd_req = sel && (data_read_n != 2'b11);
  assign a_tx   = (data_addr == 4'h0);
  assign a_stat = (data_addr == 4'h4);
  assign a_div  = (data_addr == 4'h8);

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign head       = fifo_mem[rd_ptr];

  // wr_done stops a held write request from committing twice
  always_comb begin
    data_ready = 1'b0;
    if (wr_req) begin
      data_ready = !wr_done && !(a_tx && fifo_full);
    end else if (rd_req) begin
      data_ready = 1'b1;
    end
  end

  assign wr_acc = wr_req && data_ready;
  assign push   = wr_acc && a_tx;

  assign status = {23'd0, 5'(level), 1'b0,
                   fifo_empty, fifo_full, (state != IDLE)};

  always_comb begin
    data_out = 32'd0;
    if (rd_req) begin
      if (a_stat) data_out = status;
      else if (a_div) data_out = {16'd0, divisor};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done <= 1'b0;
    end else if (!wr_req) begin
      wr_done <= 1'b0;
    end else if (wr_acc) begin
      wr_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= DIV_RESET;
    end else if (wr_acc && a_div) begin
      if (data_write_n == 2'b00) divisor[7:0] <= data_in[7:0];
      else divisor <= data_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // txd is registered from the current state, so the line lags the
  // state by one cycle; irq_empty is registered the same way to stay
  // aligned with the end of the stop bit on the wire.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    pop       = 1'b0;
    txd_n     = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = head;
          cnt_n   = divisor;
          state_n = START;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (cnt == 16'd0) begin
          cnt_n     = divisor;
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        txd_n = shreg[0];
        if (cnt == 16'd0) begin
          cnt_n     = divisor;
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (cnt == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = head;
            cnt_n   = divisor;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      shreg     <= 8'd0;
      bit_idx   <= 3'd0;
      uart_txd  <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      bit_idx   <= bit_idx_n;
      uart_txd  <= txd_n;
      irq_empty <= fifo_empty && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_tinyqv_uart_tx_periph.sv
// Bench for tinyqv_uart_tx_periph: directed + random frames
// checked against an arithmetic model of the UART waveform.
module tb_tinyqv_uart_tx_periph;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [3:0]  data_addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;
  logic        uart_txd;
  logic        irq_empty;

  tinyqv_uart_tx_periph dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .data_addr    (data_addr),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .uart_txd     (uart_txd),
    .irq_empty    (irq_empty)
  );

  localparam int LOGN = 16384;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic txd_log [LOGN];
  logic irq_log [LOGN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = k holds the values registered at the k-th rising edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (cyc < LOGN) begin
      txd_log[cyc] = uart_txd;
      irq_log[cyc] = irq_empty;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // expected line level t cycles after the start bit begins
  function automatic logic exp_txd(input logic [7:0] b, input int t,
                                   input int fl, input int bl);
    int k;
    if (t < fl) return 1'b0;
    k = (t - fl) / bl;
    if (k < 8) return b[k];
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b,
                             input int s, input int fl, input int bl);
    int bad = 0;
    for (int t = 0; t < fl + 9 * bl; t++) begin
      if (txd_log[s + t] !== exp_txd(b, t, fl, bl)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic count_low(input string tag, input int a, input int b);
    int lows = 0;
    for (int i = a; i <= b; i++) if (txd_log[i] !== 1'b1) lows++;
    chk(tag, lows, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] wn,
                    input logic [31:0] d, input int hold,
                    output int acc, output int stalls);
    stalls = 0;
    acc = -1;
    sel = 1'b1;
    data_addr = a;
    data_write_n = wn;
    data_in = d;
    #1;
    while (!data_ready && stalls < 2000) begin
      step();
      stalls++;
    end
    if (!data_ready) begin
      chk("wr_timeout", 32'd1, 32'd0);
    end else begin
      step();
      acc = cyc;
      repeat (hold) step();
    end
    sel = 1'b0;
    data_write_n = 2'b11;
    step();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1;
    data_addr = a;
    data_read_n = 2'b10;
    #1;
    chk("rd_ready", 32'(data_ready), 32'd1);
    v = data_out;
    step();
    sel = 1'b0;
    data_read_n = 2'b11;
    step();
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  bq [6];
    int          n;
    int          s;
    int          d;
    int          acc [6];
    int          st [6];

    rst = 1'b1;
    sel = 1'b0;
    data_addr = 4'h0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    data_in = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    step();

    // reset state
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_irq", 32'(irq_empty), 32'd1);
    chk("rst_dout", data_out, 32'd0);
    rd(4'h4, v);
    chk("rst_status", v, 32'h4);
    rd(4'h8, v);
    chk("rst_div", v, 32'd433);
    data_write_n = 2'b10;
    #1;
    chk("nosel_ready", 32'(data_ready), 32'd0);
    data_write_n = 2'b11;
    sel = 1'b1;
    #1;
    chk("noreq_ready", 32'(data_ready), 32'd0);
    sel = 1'b0;
    step();

    // single frame, request held past acceptance
    wr(4'h8, 2'b10, 32'd3, 0, n, s);
    r = $urandom;
    wr(4'h0, 2'b10, {r[31:8], 8'hA5}, 2, n, s);
    wait_until(n + 60);
    chk("t2_pre", 32'(txd_log[n + 1]), 32'd1);
    check_frame("t2_frame", 8'hA5, n + 2, 4, 4);
    chk("t2_irq_lo", 32'(irq_log[n + 41]), 32'd0);
    chk("t2_irq_hi", 32'(irq_log[n + 42]), 32'd1);
    count_low("t2_no_dup", n + 42, n + 59);
    rd(4'h4, v);
    chk("t2_status", v, 32'h4);

    // six writes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      bq[i] = 8'(i + 1);
      wr(4'h0, 2'b00, 32'(i + 1), 0, acc[i], st[i]);
    end
    for (int i = 0; i < 5; i++) chk("t3_nostall", st[i], 0);
    chk("t3_acc6", acc[5], acc[0] + 42);
    wait_until(acc[0] + 250);
    for (int k = 0; k < 6; k++)
      check_frame("t3_frame", bq[k], acc[0] + 2 + 40 * k, 4, 4);
    chk("t3_irq_lo", 32'(irq_log[acc[0] + 241]), 32'd0);
    chk("t3_irq_hi", 32'(irq_log[acc[0] + 242]), 32'd1);

    // divisor change during the start bit
    wr(4'h0, 2'b00, 32'h0F, 0, n, s);
    wr(4'h8, 2'b10, 32'd7, 0, d, s);
    chk("t5_div_acc", d, n + 2);
    wait_until(n + 85);
    check_frame("t5_frame", 8'h0F, n + 2, 4, 8);
    chk("t5_irq_lo", 32'(irq_log[n + 77]), 32'd0);
    chk("t5_irq_hi", 32'(irq_log[n + 78]), 32'd1);
    wr(4'h8, 2'b10, 32'd3, 0, n, s);

    // async reset mid-frame with a second byte queued
    r = $urandom;
    b = r[7:0] & 8'hF7;
    wr(4'h0, 2'b00, 32'(b), 0, n, s);
    wr(4'h0, 2'b00, 32'(r[15:8]), 0, d, s);
    wait_until(n + 19);
    chk("t4_bit3", 32'(uart_txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_txd_async", 32'(uart_txd), 32'd1);
    chk("t4_irq_async", 32'(irq_empty), 32'd1);
    step();
    step();
    rst = 1'b0;
    s = cyc;
    rd(4'h4, v);
    chk("t4_status", v, 32'h4);
    rd(4'h8, v);
    chk("t4_div", v, 32'd433);
    wait_until(s + 60);
    count_low("t4_silent", s, s + 60);

    // partial divisor writes and unmapped offsets
    r = $urandom;
    wr(4'h8, 2'b10, {r[31:16], 16'h1234}, 0, n, s);
    r = $urandom;
    wr(4'h8, 2'b00, {r[31:8], 8'hFF}, 0, n, s);
    rd(4'h8, v);
    chk("t6_div", v, 32'h12FF);
    rd(4'hC, v);
    chk("t6_unmapped", v, 32'd0);
    rd(4'h0, v);
    chk("t6_txdata_rd", v, 32'd0);
    sel = 1'b1;
    data_addr = 4'hC;
    data_write_n = 2'b10;
    #1;
    chk("t6_unmapped_wr", 32'(data_ready), 32'd1);
    sel = 1'b0;
    data_write_n = 2'b11;
    step();
    step();

    // random divisors and bytes
    for (int rep = 0; rep < 3; rep++) begin
      d = $urandom_range(0, 4);
      wr(4'h8, 2'b01, 32'(d), 0, n, s);
      for (int i = 0; i < 3; i++) begin
        r = $urandom;
        bq[i] = r[7:0];
        wr(4'h0, 2'b00, r, 0, acc[i], st[i]);
      end
      wait_until(acc[0] + 2 + 30 * (d + 1) + 4);
      for (int k = 0; k < 3; k++)
        check_frame("t7_frame", bq[k], acc[0] + 2 + 10 * (d + 1) * k,
                    d + 1, d + 1);
      chk("t7_irq_lo", 32'(irq_log[acc[0] + 1 + 30 * (d + 1)]), 32'd0);
      chk("t7_irq_hi", 32'(irq_log[acc[0] + 2 + 30 * (d + 1)]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
